// File: rtl/adder_reg_10b_pkg.sv
// Shared fetch-path constants: PC width and reset address.
// Reused by fetch and decode so both agree on the PC format.
package adder_reg_10b_pkg;

  localparam int unsigned PC_W = 10;
  localparam logic [PC_W-1:0] PC_RESET = 10'h000;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder cell; chained by adder_reg_10b into a ripple-carry adder.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_reg_10b.sv
// Next-PC datapath: ripple-carry adder (sum/cout) feeding a write-enabled PC register (q).
// sum and cout stay visible so fetch logic can see the next PC before it is stored.
module adder_reg_10b
  import adder_reg_10b_pkg::*;
#(
  parameter int unsigned      WIDTH   = PC_W,
  parameter logic [WIDTH-1:0] RST_VAL = PC_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             wen,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] q_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1b u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  // Reset dominates wen at the same edge and clears q without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else if (wen) begin
      q_q <= sum;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_adder_reg_10b.sv
// Directed and random checks of adder_reg_10b against an arithmetic reference model.
module tb_adder_reg_10b;

  logic       clk;
  logic       rst;
  logic [9:0] a;
  logic [9:0] b;
  logic       cin;
  logic       wen;
  logic [9:0] sum;
  logic       cout;
  logic [9:0] q;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [9:0]  exp_q;

  adder_reg_10b u_dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .wen  (wen),
    .sum  (sum),
    .cout (cout),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ref_add(input logic [9:0] x, input logic [9:0] y,
                                          input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[10:0];
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge, updating the model from the inputs present before it.
  task automatic tick();
    logic [10:0] r;
    r = ref_add(a, b, cin);
    @(posedge clk);
    if (!rst)     exp_q = 10'h000;
    else if (wen) exp_q = r[9:0];
    #1;
  endtask

  task automatic chk_add(input string tag);
    logic [10:0] r;
    r = ref_add(a, b, cin);
    chk({tag, "_sum"}, {1'b0, sum}, {1'b0, r[9:0]});
    chk({tag, "_cout"}, {10'h0, cout}, {10'h0, r[10]});
  endtask

  initial begin
    exp_q = 10'h000;
    rst = 1'b0; wen = 1'b1; a = 10'h055; b = 10'h003; cin = 1'b0;

    // Reset held while clk runs with wen=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold_q", {1'b0, q}, 11'h000);
    end
    rst = 1'b1;
    tick();
    chk("reset_release_q", {1'b0, q}, 11'h058);

    // Simple add
    a = 10'h014; b = 10'h001; cin = 1'b0; #1;
    chk("add_sum", {1'b0, sum}, 11'h015);
    chk("add_cout", {10'h0, cout}, 11'h000);
    tick();
    chk("add_q", {1'b0, q}, 11'h015);

    // Wrap cases
    a = 10'h3FF; b = 10'h001; cin = 1'b0; #1;
    chk("wrap1_sum", {1'b0, sum}, 11'h000);
    chk("wrap1_cout", {10'h0, cout}, 11'h001);
    a = 10'h3FF; b = 10'h3FF; cin = 1'b1; #1;
    chk("wrap2_sum", {1'b0, sum}, 11'h3FF);
    chk("wrap2_cout", {10'h0, cout}, 11'h001);

    // Hold with wen=0
    a = 10'h123; b = 10'h000; cin = 1'b0; wen = 1'b1;
    tick();
    chk("hold_load_q", {1'b0, q}, 11'h123);
    wen = 1'b0; a = 10'h200; b = 10'h001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", {1'b0, q}, 11'h123);
      chk("hold_sum", {1'b0, sum}, 11'h201);
    end

    // Asynchronous reset between edges
    wen = 1'b1; a = 10'h0AA; b = 10'h000;
    tick();
    chk("async_load_q", {1'b0, q}, 11'h0AA);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", {1'b0, q}, 11'h000);
    tick();
    chk("async_rst_edge_q", {1'b0, q}, 11'h000);
    rst = 1'b1;
    exp_q = 10'h000;

    // PC increment loop with q fed back to a
    a = 10'h014; b = 10'h000; cin = 1'b0; wen = 1'b1;
    tick();
    chk("loop_start_q", {1'b0, q}, 11'h014);
    b = 10'h001;
    for (int i = 1; i <= 3; i++) begin
      a = q;
      tick();
      chk("loop_q", {1'b0, q}, 11'h014 + 11'(i));
    end

    // Random sweep: adder against arithmetic model, register against tracked q
    for (int i = 0; i < 1000; i++) begin
      a   = 10'($urandom);
      b   = 10'($urandom);
      cin = 1'($urandom);
      wen = ($urandom_range(3, 0) != 0);
      #1;
      chk_add("rand");
      tick();
      chk("rand_q", {1'b0, q}, {1'b0, exp_q});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
